// File: rtl/icap_access_arbiter_if.sv
// Requester-side bus of the ICAP access arbiter: per-requester request/done
// levels in, registered one-hot grant and its index out.
interface icap_access_arbiter_if #(
  parameter int NUM_REQ = 2
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx
  );
endinterface

// File: rtl/icap_access_arbiter.sv
// ICAP access arbiter: waits for a stable EOS, then hands the single ICAP port
// round-robin to its requesters, bounds every grant with a watchdog and answers
// STARTUPE2 PREQ with PACK only between transfers.
module icap_access_arbiter #(
  parameter int NUM_REQ           = 2,
  parameter int EOS_STABLE_CYCLES = 16,
  parameter int MAX_GRANT_CYCLES  = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 eos,
  input  logic                 preq,
  output logic                 pack,
  output logic                 icap_csib,
  output logic                 ready,
  output logic                 timeout_err,
  icap_access_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(EOS_STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] EOS_PRE   = CNT_W'(EOS_STABLE_CYCLES - 1);
  localparam bit               WD_ENABLE = (MAX_GRANT_CYCLES != 0);
  localparam logic [15:0]      WD_LAST   = WD_ENABLE ? 16'(MAX_GRANT_CYCLES - 1) : 16'd0;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    WAIT_EOS,
    IDLE,
    GRANT,
    PROG_ACK
  } state_t;

  state_t             state;
  logic               eos_meta;
  logic               eos_s;
  logic               preq_meta;
  logic               preq_s;
  logic [CNT_W-1:0]   stable_cnt;
  logic [15:0]        wdog;
  logic [IDX_W-1:0]   last_idx;
  logic [NUM_REQ-1:0] grant_r;
  logic [IDX_W-1:0]   grant_idx_r;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;
  logic               cur_done;
  logic               cur_req;

  assign bus.grant     = grant_r;
  assign bus.grant_idx = grant_idx_r;
  assign cur_done      = bus.done[grant_idx_r];
  assign cur_req       = bus.req[grant_idx_r];

  // Round-robin pick: first active request scanning upward from the one after the last winner.
  always_comb begin
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_idx) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Synchronizers, EOS qualification, arbitration FSM, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_EOS;
      eos_meta    <= 1'b0;
      eos_s       <= 1'b0;
      preq_meta   <= 1'b0;
      preq_s      <= 1'b0;
      stable_cnt  <= '0;
      wdog        <= '0;
      last_idx    <= LAST_INIT;
      grant_r     <= '0;
      grant_idx_r <= '0;
      icap_csib   <= 1'b1;
      pack        <= 1'b0;
      ready       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      eos_meta  <= eos;
      eos_s     <= eos_meta;
      preq_meta <= preq;
      preq_s    <= preq_meta;

      case (state)
        WAIT_EOS: begin
          if (!eos_s) begin
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
            if (stable_cnt == EOS_PRE) begin
              ready <= 1'b1;
              state <= IDLE;
            end
          end
        end

        IDLE: begin
          if (preq_s) begin
            pack  <= 1'b1;
            state <= PROG_ACK;
          end else if (pick_valid) begin
            grant_r     <= ONE_HOT0 << pick_idx;
            grant_idx_r <= pick_idx;
            last_idx    <= pick_idx;
            icap_csib   <= 1'b0;
            wdog        <= '0;
            state       <= GRANT;
          end
        end

        GRANT: begin
          if (wdog != 16'hFFFF) begin
            wdog <= wdog + 1'b1;
          end
          if (cur_done || !cur_req) begin
            grant_r   <= '0;
            icap_csib <= 1'b1;
            state     <= IDLE;
          end else if (WD_ENABLE && (wdog == WD_LAST)) begin
            grant_r     <= '0;
            icap_csib   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end

        PROG_ACK: begin
          if (!preq_s) begin
            pack  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= WAIT_EOS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icap_access_arbiter.sv
// Scoreboard bench for icap_access_arbiter: directed scenarios push the grants
// they expect, a negedge monitor pops and compares each new grant and checks the
// output invariants every cycle.
module tb_icap_access_arbiter;

  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic eos;
  logic preq;
  logic pack;
  logic icap_csib;
  logic ready;
  logic timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1:0] exp_q[$];
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] mon_exp;

  icap_access_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  icap_access_arbiter #(
    .NUM_REQ          (NUM_REQ),
    .EOS_STABLE_CYCLES(16),
    .MAX_GRANT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .eos        (eos),
    .preq       (preq),
    .pack       (pack),
    .icap_csib  (icap_csib),
    .ready      (ready),
    .timeout_err(timeout_err),
    .bus        (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive the request vector and queue the grants it should produce, oldest in the low bits.
  task automatic applyStimulus(input logic [1:0] reqv, input logic [7:0] exps, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exps[2*i +: 2]);
    end
    bus.req = reqv;
  endtask

  task automatic waitGrant(input string name, input int budget);
    int k;
    k = 0;
    while (bus.grant == 2'b00 && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput({name, "_grant_seen"}, 32'(bus.grant != 2'b00), 32'd1);
  endtask

  task automatic waitPackLow(input int budget);
    int k;
    k = 0;
    while (pack && k < budget) begin
      tick(1);
      k++;
    end
    checkOutput("pack_released", 32'(pack), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_grant"}, 32'(bus.grant), 32'd0);
    checkOutput({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'd0);
    checkOutput({tag, "_csib"}, 32'(icap_csib), 32'd1);
    checkOutput({tag, "_pack"}, 32'(pack), 32'd0);
    checkOutput({tag, "_ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Monitor: match every newly raised grant against the scoreboard and check invariants each cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.grant != 2'b00 && prev_grant == 2'b00) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_grant: got %b, expected no grant at %0t", bus.grant, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          checkOutput("grant_order", 32'(bus.grant), 32'(mon_exp));
          checkOutput("grant_idx", 32'(bus.grant_idx), (mon_exp == 2'b10) ? 32'd1 : 32'd0);
        end
      end
    end
    checkOutput("csib_vs_grant", 32'(icap_csib), 32'(~|bus.grant));
    checkOutput("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    checkOutput("pack_grant_excl", 32'(pack & (|bus.grant)), 32'd0);
    prev_grant = bus.grant;
  end

  // Hard stop in case a scenario wedges.
  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] global timeout");
  end

  // Directed scenarios.
  initial begin
    int wd_cycles;
    rst_n    = 1'b0;
    eos      = 1'b0;
    preq     = 1'b0;
    bus.req  = 2'b00;
    bus.done = 2'b00;
    tick(3);
    checkResetOutputs("reset");

    // EOS qualification with a one-cycle dropout; requests must be ignored.
    rst_n   = 1'b1;
    eos     = 1'b1;
    bus.req = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("eos_first_grant", 32'(bus.grant), 32'd0);
    end
    eos = 1'b0;
    tick(1);
    eos = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      checkOutput("eos_not_ready", 32'(ready), 32'd0);
      checkOutput("eos_grant", 32'(bus.grant), 32'd0);
    end
    tick(1);
    checkOutput("eos_ready", 32'(ready), 32'd1);
    bus.req = 2'b00;
    tick(2);
    checkOutput("idle_no_grant", 32'(bus.grant), 32'd0);

    // Round-robin with done pulses four cycles into each grant.
    applyStimulus(2'b11, 8'b10_01_10_01, 4);
    for (int g = 0; g < 4; g++) begin
      waitGrant("rr", 10);
      tick(3);
      bus.done = (g % 2 == 0) ? 2'b01 : 2'b10;
      tick(1);
      bus.done = 2'b00;
      if (g == 3) bus.req = 2'b00;
      checkOutput("rr_release_grant", 32'(bus.grant), 32'd0);
      checkOutput("rr_release_csib", 32'(icap_csib), 32'd1);
    end
    tick(2);

    // Single-cycle grant latency and release on request drop.
    applyStimulus(2'b10, 8'b0000_0010, 1);
    tick(1);
    checkOutput("lat_grant", 32'(bus.grant), 32'd2);
    checkOutput("lat_csib", 32'(icap_csib), 32'd0);
    checkOutput("lat_idx", 32'(bus.grant_idx), 32'd1);
    tick(2);
    bus.req = 2'b00;
    tick(1);
    checkOutput("drop_grant", 32'(bus.grant), 32'd0);
    checkOutput("drop_csib", 32'(icap_csib), 32'd1);
    tick(1);

    // PREQ arriving mid-grant waits for the transfer, then blocks new grants.
    applyStimulus(2'b01, 8'b0000_0001, 1);
    waitGrant("preq_first", 10);
    preq = 1'b1;
    tick(4);
    checkOutput("preq_grant_kept", 32'(bus.grant), 32'd1);
    checkOutput("preq_pack_wait", 32'(pack), 32'd0);
    bus.done = 2'b01;
    bus.req  = 2'b10;
    tick(1);
    bus.done = 2'b00;
    checkOutput("preq_done_grant", 32'(bus.grant), 32'd0);
    tick(1);
    checkOutput("pack_set", 32'(pack), 32'd1);
    checkOutput("pack_no_grant", 32'(bus.grant), 32'd0);
    tick(5);
    checkOutput("pack_held", 32'(pack), 32'd1);
    checkOutput("pack_held_no_grant", 32'(bus.grant), 32'd0);
    applyStimulus(2'b10, 8'b0000_0010, 1);
    preq = 1'b0;
    waitPackLow(10);
    waitGrant("post_pack", 10);
    checkOutput("post_pack_grant", 32'(bus.grant), 32'd2);
    bus.req = 2'b00;
    tick(2);

    // Watchdog revokes a grant that never finishes; the other requester follows.
    checkOutput("wd_err_clear", 32'(timeout_err), 32'd0);
    applyStimulus(2'b11, 8'b0000_1001, 2);
    waitGrant("wd_first", 10);
    wd_cycles = 0;
    while (bus.grant != 2'b00 && wd_cycles < 20) begin
      tick(1);
      wd_cycles++;
    end
    checkOutput("wd_cycles", 32'(wd_cycles), 32'd8);
    checkOutput("wd_err_set", 32'(timeout_err), 32'd1);
    waitGrant("wd_next", 10);
    tick(2);
    checkOutput("wd_next_grant", 32'(bus.grant), 32'd2);
    checkOutput("wd_err_sticky", 32'(timeout_err), 32'd1);

    // Reset while granted drops everything on that edge.
    rst_n   = 1'b0;
    bus.req = 2'b00;
    tick(1);
    checkResetOutputs("midreset");
    rst_n = 1'b1;
    tick(3);
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_grant", 32'(bus.grant), 32'd0);
    checkOutput("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
